logicunit_sched: RTL and testbench
==================================

// Module: logicunit_sched
// PURPOSE
//  Shares one SLICE-bit logic-unit slice between two requesters. Each request is a WIDTH-bit bitwise op.
//  The block arbitrates round-robin, streams the operands through the slice SLICE bits per cycle,
//  assembles the WIDTH-bit result, and returns it on a valid/ready response channel tagged with requester id.
//  Sits between ALU-side clients and the shared logic unit; control encoding is identical to logicunit.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  SLICE  8   bits processed per cycle; WIDTH % SLICE == 0 required (elaboration error otherwise)
// PORTS
//  clk           in   1      single clock, rising edge
//  reset         in   1      asynchronous, active-high reset
//  req0_valid    in   1      requester 0 has an op
//  req0_ready    out  1      requester 0 op accepted this cycle (valid&ready)
//  req0_a        in   WIDTH  operand A
//  req0_b        in   WIDTH  operand B
//  req0_control  in   2      00 AND, 01 OR, 10 NOR, 11 XOR
//  req1_*        (same five signals for requester 1)
//  resp_valid    out  1      result available
//  resp_ready    in   1      consumer takes result
//  resp_id       out  1      requester that issued the result
//  resp_out      out  WIDTH  result
//  busy          out  1      state != IDLE
// BEHAVIOUR
//  Reset (async, any time): state=IDLE, slice counter=0, result reg=0, resp_valid=0, resp_id=0,
//   priority pointer=0 (req0 favoured). An op in flight is discarded; no response is ever produced for it.
//  Outputs while reset is high: req*_ready=0, busy=0.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: grant = the only valid requester, or pointer's requester if both are valid.
//    reqX_ready = (state==IDLE) & reqX_valid & grant==X (combinational). At most one ready per cycle.
//    On handshake: latch a, b, control, id; counter=0; -> RUN. No valid: stay in IDLE.
//   RUN: cycle k (k=0..N-1, N=WIDTH/SLICE) computes bits [k*SLICE +: SLICE].
//    Result is registered at the edge ending cycle k. Counter==N-1 at the edge: -> DONE.
//   DONE: resp_valid=1. resp_out and resp_id are held stable until resp_ready.
//    On resp_valid&resp_ready: pointer = ~resp_id; -> IDLE.
//  Latency: accept at edge E0; resp_valid is high in the cycle after edge EN (N=4 by default).
//   Minimum op period is N+2 cycles. No accept in RUN or DONE; no bypass.
//  Requesters hold a/b/control stable while valid. A valid may drop before ready without effect.
//  The result reg holds the last result after the DONE handshake. resp_out is only meaningful with resp_valid.
//  The pointer updates only on response completion, never on grant, which gives strict alternation under
//   contention.
// STRUCTURE
//  Package lu_pkg: localparams LU_AND=2'b00, LU_OR=2'b01, LU_NOR=2'b10, LU_XOR=2'b11;
//   state encoding S_IDLE/S_RUN/S_DONE.
//  Sub-module logicunit_slice #(SLICE): combinational out[SLICE]=op(a,b,control), bitwise; one instance.
//  Top level holds the arbiter, FSM, counter, operand regs, result reg and pointer.
// TESTING
//  1 reset high, all valids=0 -> resp_valid=0, busy=0, req*_ready=0; release -> stays idle.
//  2 req0 AND a=F0F0F0F0 b=FF00FF00 -> ready0 one cycle; resp_valid 4 cycles after accept edge;
//    out=F000F000, id=0.
//  3 both valid after reset, req0 XOR a=FFFF0000 b=0F0F0F0F, req1 OR a=0 b=12345678 ->
//    req0 served first (out=F0F00F0F,id=0), then req1 (out=12345678,id=1).
//  4 both kept valid for 4 ops -> ids alternate 0,1,0,1; ready never high outside IDLE.
//  5 req1 NOR a=0 b=0, resp_ready low 3 cycles -> out=FFFFFFFF, id=1 held; busy=1; ready0/1=0 throughout.
//  6 reset pulse during RUN (counter=2) of req0 OR -> no resp_valid; next req1 AND a=b=A5A5A5A5 ->
//    out=A5A5A5A5, id=1.

Source files
------------

// File: rtl/lu_pkg.sv
// Shared definitions for the shared logic-unit scheduler.
// Contents:
//   LU_AND/LU_OR/LU_NOR/LU_XOR - 2-bit control encodings (same as logicunit)
//   state_t                    - scheduler FSM state encoding
package lu_pkg;

    localparam logic [1:0] LU_AND = 2'b00;
    localparam logic [1:0] LU_OR  = 2'b01;
    localparam logic [1:0] LU_NOR = 2'b10;
    localparam logic [1:0] LU_XOR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/logicunit_slice.sv
// Combinational SLICE-bit logic unit: out = op(a, b) bitwise.
// Ports:
//   a, b     in  SLICE  operand slices
//   control  in  2      00 AND, 01 OR, 10 NOR, 11 XOR
//   out      out SLICE  result slice
module logicunit_slice
    import lu_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [1:0]       control,
    output logic [SLICE-1:0] out
);

    // Bitwise operation selected by control.
    always_comb begin
        out = {SLICE{1'b0}};
        case (control)
            LU_AND:  out = a & b;
            LU_OR:   out = a | b;
            LU_NOR:  out = ~(a | b);
            LU_XOR:  out = a ^ b;
            default: out = {SLICE{1'b0}};
        endcase
    end

endmodule

// File: rtl/logicunit_sched.sv
// Shares one SLICE-bit logic-unit slice between two requesters. Requests are
// arbitrated round-robin, operands are streamed through the slice SLICE bits
// per cycle, and the assembled WIDTH-bit result is returned on a valid/ready
// response channel tagged with the requester id.
// Ports:
//   clk, reset                      clock, async active-high reset
//   reqN_valid/ready/a/b/control    request channel of requester N (N=0,1)
//   resp_valid/ready/id/out         response channel
//   busy                            FSM not idle
module logicunit_sched
    import lu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_control,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_control,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_out,
    output logic             busy
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH % SLICE) != 0) begin : g_width_check
        $error("logicunit_sched: WIDTH must be a multiple of SLICE");
    end

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [1:0]       ctrl_r;
    logic             id_r;
    logic [WIDTH-1:0] result_r;
    logic             ptr_r;

    logic             grant0_s;
    logic             grant1_s;
    logic [31:0]      base_s;
    logic [SLICE-1:0] sl_a_s;
    logic [SLICE-1:0] sl_b_s;
    logic [SLICE-1:0] sl_out_s;

    // Arbitration: a lone requester wins; under contention the pointer decides.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0_s = ~ptr_r;
            grant1_s = ptr_r;
        end else begin
            grant0_s = req0_valid;
            grant1_s = req1_valid;
        end
    end

    // Ready is only offered in IDLE and is forced low while reset is asserted.
    assign req0_ready = ~reset & (state_r == S_IDLE) & grant0_s;
    assign req1_ready = ~reset & (state_r == S_IDLE) & grant1_s;

    assign base_s = 32'(cnt_r) * 32'(SLICE);
    assign sl_a_s = a_r[base_s +: SLICE];
    assign sl_b_s = b_r[base_s +: SLICE];

    logicunit_slice #(
        .SLICE(SLICE)
    ) u_slice (
        .a       (sl_a_s),
        .b       (sl_b_s),
        .control (ctrl_r),
        .out     (sl_out_s)
    );

    // Scheduler FSM: accept in IDLE, stream slices in RUN, hold result in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= S_IDLE;
            cnt_r    <= {CW{1'b0}};
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            ctrl_r   <= 2'b00;
            id_r     <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            ptr_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (grant0_s || grant1_s) begin
                        a_r     <= grant1_s ? req1_a : req0_a;
                        b_r     <= grant1_s ? req1_b : req0_b;
                        ctrl_r  <= grant1_s ? req1_control : req0_control;
                        id_r    <= grant1_s;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= S_RUN;
                    end
                end
                S_RUN: begin
                    result_r[base_s +: SLICE] <= sl_out_s;
                    if (cnt_r == LAST) begin
                        state_r <= S_DONE;
                    end else begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    // Pointer moves only on completion, giving strict alternation.
                    if (resp_ready) begin
                        ptr_r   <= ~id_r;
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign resp_valid = (state_r == S_DONE);
    assign resp_id    = id_r;
    assign resp_out   = result_r;
    assign busy       = (state_r != S_IDLE);

endmodule

// File: tb/tb_logicunit_sched.sv
// Directed self-checking bench for logicunit_sched (WIDTH=32, SLICE=8).
module tb_logicunit_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic [1:0]  req0_control;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic [1:0]  req1_control;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_out;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n;

    logicunit_sched dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_control (req0_control),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_control (req1_control),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_out     (resp_out),
        .busy         (busy)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a response, check it, then complete the handshake.
    task automatic get_resp(input string tag, input logic [31:0] exp_out, input logic exp_id);
        int k;
        k = 0;
        while (resp_valid !== 1'b1 && k < 40) begin
            if (busy === 1'b1)
                check({tag, "_rdy_busy"}, {31'd0, req0_ready | req1_ready}, 32'd0);
            tick();
            k++;
        end
        check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_out"}, resp_out, exp_out);
        check({tag, "_id"}, {31'd0, resp_id}, {31'd0, exp_id});
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_control = 2'b00;
        req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_control = 2'b00;
        resp_ready = 1'b0;

        // 1: reset state, ready suppressed while reset is high
        tick(); tick();
        check("t1_valid", {31'd0, resp_valid}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("t1_rdy0", {31'd0, req0_ready}, 32'd0);
        check("t1_rdy1", {31'd0, req1_ready}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;
        tick(); tick();
        check("t1_idle_busy", {31'd0, busy}, 32'd0);
        check("t1_idle_valid", {31'd0, resp_valid}, 32'd0);

        // 2: single AND op, latency 4 edges after accept
        req0_a = 32'hF0F0F0F0; req0_b = 32'hFF00FF00; req0_control = 2'b00; req0_valid = 1'b1;
        #1;
        check("t2_rdy0", {31'd0, req0_ready}, 32'd1);
        check("t2_rdy1", {31'd0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("t2_busy", {31'd0, busy}, 32'd1);
        check("t2_rdy0_run", {31'd0, req0_ready}, 32'd0);
        n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("t2_lat", n, 32'd4);
        check("t2_out", resp_out, 32'hF000F000);
        check("t2_id", {31'd0, resp_id}, 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("t2_done_valid", {31'd0, resp_valid}, 32'd0);
        check("t2_done_busy", {31'd0, busy}, 32'd0);

        // 3: contention right after reset, req0 favoured first
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F; req0_control = 2'b11; req0_valid = 1'b1;
        req1_a = 32'h00000000; req1_b = 32'h12345678; req1_control = 2'b01; req1_valid = 1'b1;
        #1;
        check("t3_rdy0", {31'd0, req0_ready}, 32'd1);
        check("t3_rdy1", {31'd0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0;
        get_resp("t3_r0", 32'hF0F00F0F, 1'b0);
        #1;
        check("t3_rdy1_next", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        get_resp("t3_r1", 32'h12345678, 1'b1);

        // 4: both held valid for 4 ops, ids alternate
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            get_resp($sformatf("t4_op%0d", i), (i % 2 == 1) ? 32'h12345678 : 32'hF0F00F0F, (i % 2 == 1));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // 5: NOR with delayed resp_ready; result and id held, no accepts in DONE
        req1_a = 32'h00000000; req1_b = 32'h00000000; req1_control = 2'b10; req1_valid = 1'b1;
        tick();
        req1_valid = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("t5_valid", {31'd0, resp_valid}, 32'd1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t5_out%0d", i), resp_out, 32'hFFFFFFFF);
            check($sformatf("t5_id%0d", i), {31'd0, resp_id}, 32'd1);
            check($sformatf("t5_busy%0d", i), {31'd0, busy}, 32'd1);
            check($sformatf("t5_rdy0_%0d", i), {31'd0, req0_ready}, 32'd0);
            check($sformatf("t5_rdy1_%0d", i), {31'd0, req1_ready}, 32'd0);
            tick();
        end
        check("t5_still_valid", {31'd0, resp_valid}, 32'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("t5_done_valid", {31'd0, resp_valid}, 32'd0);

        // 6: reset during RUN discards the op; next op completes normally
        req0_a = 32'h12340000; req0_b = 32'h00005678; req0_control = 2'b01; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #2;
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_valid", {31'd0, resp_valid}, 32'd0);
        check("t6_rst_out", resp_out, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("t6_novalid%0d", i), {30'd0, busy, resp_valid}, 32'd0);
        end
        req1_a = 32'hA5A5A5A5; req1_b = 32'hA5A5A5A5; req1_control = 2'b00; req1_valid = 1'b1;
        #1;
        check("t6_rdy1", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        get_resp("t6_r1", 32'hA5A5A5A5, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
